// File: rtl/dac_channel_scheduler.sv
// Round-robin arbiter sharing one SPI DAC driver among NCH requesters, with a dacdone watchdog.
// Define DAC_READBACK_CHECK_EN to compare the driver's echoed word against the previously completed frame.
module dac_channel_scheduler #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    input  logic [NCH-1:0]    req,
    input  logic [12*NCH-1:0] req_data,
    output logic [NCH-1:0]    ack,
    output logic [11:0]       data,
    output logic [3:0]        address,
    output logic [3:0]        command,
    output logic              dactrig,
    input  logic              dacdone,
    input  logic [31:0]       dac_datareceived,
    output logic              busy,
    output logic              timeout_err,
    output logic              readback_err,
    output logic [1:0]        dbg_state
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   g;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   grant_idx;
    logic            grant_found;
    logic            load;
    logic            clr_cnt;
    logic            inc_cnt;
    logic            expire;
    logic            done_hit;
    logic            advance;
    logic [11:0]     code [NCH];

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NCH) s = s - NCH;
        return s[IW-1:0];
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_code
        assign code[i] = req_data[12*i +: 12];
    end

    // Scan from the farthest offset down so the nearest requester at/after ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(ptr, k);
            end
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        clr_cnt    = 1'b0;
        inc_cnt    = 1'b0;
        expire     = 1'b0;
        done_hit   = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                clr_cnt    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // dacdone wins over a watchdog expiry landing in the same cycle.
                if (dacdone) begin
                    done_hit   = 1'b1;
                    state_next = ACK;
                end else if (cnt == CW'(TIMEOUT - 2)) begin
                    expire     = 1'b1;
                    advance    = 1'b1;
                    state_next = IDLE;
                end else begin
                    inc_cnt = 1'b1;
                end
            end
            ACK: begin
                advance    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            data        <= '0;
            address     <= '0;
            g           <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (load) begin
                data    <= code[grant_idx];
                address <= 4'(grant_idx);
                g       <= grant_idx;
            end
            if (clr_cnt)      cnt <= '0;
            else if (inc_cnt) cnt <= cnt + 1'b1;
            if (expire)  timeout_err <= 1'b1;
            if (advance) ptr <= wrap_add(g, 1);
        end
    end

    always_comb begin
        ack = '0;
        if (state == ACK) ack[g] = 1'b1;
    end

    assign command   = 4'b0011;
    assign dactrig   = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

`ifdef DAC_READBACK_CHECK_EN
    logic [19:0] rb_copy;
    logic        rb_valid;
    logic        unused_rb;

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            rb_copy      <= '0;
            rb_valid     <= 1'b0;
            readback_err <= 1'b0;
        end else if (done_hit) begin
            if (rb_valid && (dac_datareceived[23:4] != rb_copy)) readback_err <= 1'b1;
            rb_copy  <= {command, address, data};
            rb_valid <= 1'b1;
        end else if (expire) begin
            rb_valid <= 1'b0;
        end
    end

    assign unused_rb = ^{dac_datareceived[31:24], dac_datareceived[3:0]};
`else
    logic unused_rb;

    assign readback_err = 1'b0;
    assign unused_rb    = ^{dac_datareceived, done_hit};
`endif

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed bench for dac_channel_scheduler: reset, single transfer, round-robin order,
// watchdog expiry, reset mid-transfer and the readback check (when DAC_READBACK_CHECK_EN is defined).
module tb_dac_channel_scheduler;

    localparam int NCH     = 4;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [47:0] req_data;
    logic [3:0]  ack;
    logic [11:0] data;
    logic [3:0]  address;
    logic [3:0]  command;
    logic        dactrig;
    logic        dacdone;
    logic [31:0] dac_datareceived;
    logic        busy;
    logic        timeout_err;
    logic        readback_err;
    logic [1:0]  dbg_state;

    int tests_run;
    int tests_failed;
    logic [3:0] exp_q[$];

    dac_channel_scheduler #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .CLK50MHZ         (clk),
        .RST              (rst),
        .req              (req),
        .req_data         (req_data),
        .ack              (ack),
        .data             (data),
        .address          (address),
        .command          (command),
        .dactrig          (dactrig),
        .dacdone          (dacdone),
        .dac_datareceived (dac_datareceived),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .readback_err     (readback_err),
        .dbg_state        (dbg_state)
    );

    // Clock and global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish within time limit");
        $fatal(1);
    end

    // Driver tasks
    task automatic apply_reset();
        rst              = 1'b1;
        req              = '0;
        dacdone          = 1'b0;
        dac_datareceived = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_trig(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dactrig === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL trig_wait got no dactrig want dactrig within 40 cycles");
        end
    endtask

    task automatic do_transfer(input logic [3:0] r, input logic [11:0] code, input int ch,
                               input logic [31:0] echo);
        bit seen;
        req_data              = {$urandom(), $urandom()};
        req_data[12*ch +: 12] = code;
        req                   = r;
        wait_trig(seen);
        tests_run++;
        if ({address, data} !== {4'(ch), code}) begin
            tests_failed++;
            $display("FAIL xfer_grant got addr %0d data %h want addr %0d data %h", address, data, ch, code);
        end
        @(negedge clk);
        dacdone          = 1'b1;
        dac_datareceived = echo;
        @(negedge clk);
        dacdone = 1'b0;
        req     = '0;
        tests_run++;
        if (ack !== (4'b0001 << ch)) begin
            tests_failed++;
            $display("FAIL xfer_ack got %b want %b", ack, 4'b0001 << ch);
        end
        @(negedge clk);
    endtask

    // Scenario tasks
    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({data, address, dactrig, ack, busy, timeout_err, readback_err} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got data %h addr %h trig %b ack %b busy %b terr %b rerr %b want all zero",
                     data, address, dactrig, ack, busy, timeout_err, readback_err);
        end
        tests_run++;
        if ({command, dbg_state} !== {4'b0011, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_cmd_state got cmd %b state %0d want cmd 0011 state 0", command, dbg_state);
        end
    endtask

    task automatic test_single_request();
        int trig_cnt;
        logic [3:0] exp_ack;
        trig_cnt = 0;
        req_data = {12'hFFF, 12'h7A5, 12'h111, 12'h222};
        req      = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dactrig === 1'b1) trig_cnt++;
            if (c == 0) begin
                tests_run++;
                if ({address, data, busy} !== {4'd2, 12'h7A5, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL single_grant got addr %0d data %h busy %b want addr 2 data 7a5 busy 1",
                             address, data, busy);
                end
            end
            exp_ack = (c == 6) ? 4'b0100 : 4'b0000;
            tests_run++;
            if (ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL single_ack cycle %0d got %b want %b", c, ack, exp_ack);
            end
            dacdone = (c == 5);
            if (c == 6) req = '0;
        end
        tests_run++;
        if (trig_cnt != 1) begin
            tests_failed++;
            $display("FAIL single_trig_count got %0d want 1", trig_cnt);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy_after got %b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        bit seen;
        logic [3:0]  exp;
        logic [11:0] exp_code;
        apply_reset();
        exp_q = {};
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd0);
        req_data = {12'hC33, 12'hC22, 12'hC11, 12'hC00};
        req      = 4'b1111;
        while (exp_q.size() > 0) begin
            wait_trig(seen);
            exp      = exp_q.pop_front();
            exp_code = {4'hC, exp, exp};
            tests_run++;
            if ({address, data} !== {exp, exp_code}) begin
                tests_failed++;
                $display("FAIL rr_grant got addr %0d data %h want addr %0d data %h", address, data, exp, exp_code);
            end
            @(negedge clk);
            dacdone = 1'b1;
            @(negedge clk);
            dacdone = 1'b0;
            tests_run++;
            if (ack !== (4'b0001 << exp[1:0])) begin
                tests_failed++;
                $display("FAIL rr_ack got %b want %b", ack, 4'b0001 << exp[1:0]);
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit seen;
        apply_reset();
        req_data = {12'h333, 12'h222, 12'h111, 12'h000};
        req      = 4'b0110;
        wait_trig(seen);
        tests_run++;
        if (address !== 4'd1) begin
            tests_failed++;
            $display("FAIL to_first_grant got addr %0d want 1", address);
        end
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            tests_run++;
            if ({busy, timeout_err, dactrig, ack} !== {(c != 16), (c >= 16), (c == 17), 4'b0000}) begin
                tests_failed++;
                $display("FAIL to_cycle %0d got busy %b terr %b trig %b ack %b want busy %b terr %b trig %b ack 0000",
                         c, busy, timeout_err, dactrig, ack, c != 16, c >= 16, c == 17);
            end
        end
        tests_run++;
        if ({address, data} !== {4'd2, 12'h222}) begin
            tests_failed++;
            $display("FAIL to_next_grant got addr %0d data %h want addr 2 data 222", address, data);
        end
        @(negedge clk);
        dacdone = 1'b1;
        @(negedge clk);
        dacdone = 1'b0;
        req     = '0;
        tests_run++;
        if ({ack, timeout_err} !== {4'b0100, 1'b1}) begin
            tests_failed++;
            $display("FAIL to_sticky got ack %b terr %b want ack 0100 terr 1", ack, timeout_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        req_data = {12'h0D3, 12'h0D2, 12'h0D1, 12'h0D0};
        req      = 4'b0001;
        wait_trig(seen);
        tests_run++;
        if (address !== 4'd0) begin
            tests_failed++;
            $display("FAIL rw_grant got addr %0d want 0", address);
        end
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        tests_run++;
        if ({busy, dactrig, ack, timeout_err, readback_err, data, address, dbg_state} !== 26'd0) begin
            tests_failed++;
            $display("FAIL rw_reset got busy %b trig %b ack %b terr %b rerr %b data %h addr %h state %0d want all zero",
                     busy, dactrig, ack, timeout_err, readback_err, data, address, dbg_state);
        end
        rst     = 1'b0;
        dacdone = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({ack, busy} !== 5'd0) begin
            tests_failed++;
            $display("FAIL rw_stray_done got ack %b busy %b want ack 0000 busy 0", ack, busy);
        end
        dacdone = 1'b0;
        req     = 4'b1001;
        wait_trig(seen);
        req = '0;
        tests_run++;
        if ({address, data} !== {4'd0, 12'h0D0}) begin
            tests_failed++;
            $display("FAIL rw_ptr_reset got addr %0d data %h want addr 0 data 0d0", address, data);
        end
        @(negedge clk);
        dacdone = 1'b1;
        @(negedge clk);
        dacdone = 1'b0;
        tests_run++;
        if (ack !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rw_ack_after_drop got %b want 0001", ack);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rw_idle got busy %b want 0", busy);
        end
    endtask

    task automatic test_readback();
        apply_reset();
`ifdef DAC_READBACK_CHECK_EN
        do_transfer(4'b0010, 12'h123, 1, 32'hDEAD_BEEF);
        tests_run++;
        if (readback_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rb_first got %b want 0", readback_err);
        end
        do_transfer(4'b0001, 12'h456, 0, {8'h00, 4'b0011, 4'h1, 12'h123, 4'h0});
        tests_run++;
        if (readback_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rb_match got %b want 0", readback_err);
        end
        do_transfer(4'b0100, 12'h789, 2, {8'h00, 4'b0011, 4'h0, 12'h456, 4'h0} ^ 32'h0000_0010);
        tests_run++;
        if (readback_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL rb_corrupt got %b want 1", readback_err);
        end
        do_transfer(4'b1000, 12'hABC, 3, {8'h00, 4'b0011, 4'h2, 12'h789, 4'h0});
        tests_run++;
        if (readback_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL rb_sticky got %b want 1", readback_err);
        end
`else
        do_transfer(4'b0010, 12'h123, 1, $urandom());
        do_transfer(4'b0001, 12'h456, 0, $urandom());
        tests_run++;
        if (readback_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rb_disabled got %b want 0", readback_err);
        end
`endif
    endtask

    // Sequencer and final report
    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        req              = '0;
        req_data         = '0;
        dacdone          = 1'b0;
        dac_datareceived = '0;
        test_reset();
        test_single_request();
        test_round_robin();
        test_timeout();
        test_reset_in_wait();
        test_readback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
